memory_writeback_cycle: RTL and testbench

MEMORY_WRITEBACK_CYCLE -- requirements
Module: memoryWritebackCycle

---
 rtl/memory_writeback_cycle.sv | 216 +++++++++++++++++++++
 tb/tb_memory_writeback_cycle.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback_cycle.sv
// memory_writeback_cycle: memory-access and writeback stage of the pipeline.
// Accepts one op at a time from execute, issues an aligned data-memory request
// for loads and stores, extracts and extends load data, and produces a
// registered one-cycle register-file write towards decode.
module memory_writeback_cycle #(
   parameter int XLEN          = 32,
   parameter int REGISTER_SIZE = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ex_valid,
   output logic                     ex_ready,
   input  logic [XLEN-1:0]          alu_result,
   input  logic [XLEN-1:0]          pc_plus4,
   input  logic                     rf_write_enable,
   input  logic [REGISTER_SIZE-1:0] rf_write_addr,
   input  logic [1:0]               rf_write_data_sel,
   input  logic                     dm_read_enable,
   input  logic                     dm_write_enable,
   input  logic [XLEN-1:0]          dm_write_data,
   input  logic [2:0]               dm_load_type,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [XLEN-1:0]          mem_addr,
   output logic [XLEN-1:0]          mem_wdata,
   output logic [3:0]               mem_be,
   input  logic                     mem_gnt,
   input  logic                     mem_rvalid,
   input  logic [XLEN-1:0]          mem_rdata,
   output logic                     rf_writeback_enable,
   output logic [REGISTER_SIZE-1:0] rf_writeback_addr,
   output logic [XLEN-1:0]          rf_writeback_data,
   output logic                     misalign_error
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

   state_t                     state_q;

   logic                       memReq_q;
   logic                       memWe_q;
   logic [3:0]                 memBe_q;
   logic [XLEN-1:0]            memAddr_q;
   logic [XLEN-1:0]            memWdata_q;
   logic                       rfWbEnable_q;
   logic [REGISTER_SIZE-1:0]   rfWbAddr_q;
   logic [XLEN-1:0]            rfWbData_q;
   logic                       misalign_q;

   // Op fields captured at acceptance for use once memory answers
   logic                       isLoad_q;
   logic [2:0]                 loadType_q;
   logic [1:0]                 offset_q;
   logic                       wbEnable_q;
   logic [REGISTER_SIZE-1:0]   wbAddr_q;
   logic [1:0]                 wbSel_q;
   logic [XLEN-1:0]            aluResult_q;
   logic [XLEN-1:0]            pcPlus4_q;

   logic                       accept;
   logic                       isMem;
   logic                       isByte;
   logic                       isHalf;
   logic                       misaligned;
   logic                       wbEnableIn;
   logic [3:0]                 memBe_d;
   logic [XLEN-1:0]            memWdata_d;
   logic [XLEN-1:0]            aluWbData_d;
   logic [XLEN-1:0]            laneData;
   logic [XLEN-1:0]            loadData;
   logic [XLEN-1:0]            loadWbData_d;

   assign ex_ready            = (state_q == IDLE);
   assign accept              = ex_valid && ex_ready;
   assign isMem               = dm_read_enable || dm_write_enable;
   assign wbEnableIn          = rf_write_enable && (rf_write_addr != '0);

   assign mem_req             = memReq_q;
   assign mem_we              = memWe_q;
   assign mem_be              = memBe_q;
   assign mem_addr            = memAddr_q;
   assign mem_wdata           = memWdata_q;
   assign rf_writeback_enable = rfWbEnable_q;
   assign rf_writeback_addr   = rfWbAddr_q;
   assign rf_writeback_data   = rfWbData_q;
   assign misalign_error      = misalign_q;

   // Decode access size from funct3 (illegal codes act as a word), derive the
   // alignment check, byte enables and lane-replicated store data for the new op
   always_comb begin
      isByte      = (dm_load_type == 3'b000) || (dm_load_type == 3'b100);
      isHalf      = (dm_load_type == 3'b001) || (dm_load_type == 3'b101);
      misaligned  = isMem && ((isHalf && alu_result[0]) ||
                              (!isByte && !isHalf && (alu_result[1:0] != 2'b00)));
      memBe_d     = 4'b1111;
      memWdata_d  = dm_write_data;
      if (isByte) begin
         memBe_d    = 4'b0001 << alu_result[1:0];
         memWdata_d = {(XLEN/8){dm_write_data[7:0]}};
      end else if (isHalf) begin
         memBe_d    = 4'b0011 << alu_result[1:0];
         memWdata_d = {(XLEN/16){dm_write_data[15:0]}};
      end
      aluWbData_d = (rf_write_data_sel == 2'b10) ? pc_plus4 : alu_result;
   end

   // Pick the addressed lane out of the returned word, extend it, and select
   // the final writeback value for a completing memory op
   always_comb begin
      laneData = mem_rdata >> {offset_q, 3'b000};
      case (loadType_q)
         3'b000:  loadData = {{(XLEN-8){laneData[7]}}, laneData[7:0]};
         3'b001:  loadData = {{(XLEN-16){laneData[15]}}, laneData[15:0]};
         3'b100:  loadData = {{(XLEN-8){1'b0}}, laneData[7:0]};
         3'b101:  loadData = {{(XLEN-16){1'b0}}, laneData[15:0]};
         default: loadData = mem_rdata;
      endcase
      case (wbSel_q)
         2'b01:   loadWbData_d = loadData;
         2'b10:   loadWbData_d = pcPlus4_q;
         default: loadWbData_d = aluResult_q;
      endcase
   end

   // Stage FSM with all outputs registered; reset abandons any op in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         memReq_q     <= 1'b0;
         memWe_q      <= 1'b0;
         memBe_q      <= '0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         rfWbEnable_q <= 1'b0;
         rfWbAddr_q   <= '0;
         rfWbData_q   <= '0;
         misalign_q   <= 1'b0;
         isLoad_q     <= 1'b0;
         loadType_q   <= '0;
         offset_q     <= '0;
         wbEnable_q   <= 1'b0;
         wbAddr_q     <= '0;
         wbSel_q      <= '0;
         aluResult_q  <= '0;
         pcPlus4_q    <= '0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (misaligned) begin
                     misalign_q <= 1'b1;
                  end else if (isMem) begin
                     state_q     <= REQ;
                     memReq_q    <= 1'b1;
                     memWe_q     <= dm_write_enable && !dm_read_enable;
                     memAddr_q   <= {alu_result[XLEN-1:2], 2'b00};
                     memBe_q     <= memBe_d;
                     memWdata_q  <= memWdata_d;
                     isLoad_q    <= dm_read_enable;
                     loadType_q  <= dm_load_type;
                     offset_q    <= alu_result[1:0];
                     wbEnable_q  <= wbEnableIn;
                     wbAddr_q    <= rf_write_addr;
                     wbSel_q     <= rf_write_data_sel;
                     aluResult_q <= alu_result;
                     pcPlus4_q   <= pc_plus4;
                  end else begin
                     state_q      <= WB;
                     rfWbEnable_q <= wbEnableIn;
                     if (wbEnableIn) begin
                        rfWbAddr_q <= rf_write_addr;
                        rfWbData_q <= aluWbData_d;
                     end
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  memReq_q <= 1'b0;
                  memWe_q  <= 1'b0;
                  memBe_q  <= '0;
                  if (!isLoad_q) begin
                     state_q <= IDLE;
                  end else if (mem_rvalid) begin
                     state_q      <= WB;
                     rfWbEnable_q <= wbEnable_q;
                     if (wbEnable_q) begin
                        rfWbAddr_q <= wbAddr_q;
                        rfWbData_q <= loadWbData_d;
                     end
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state_q      <= WB;
                  rfWbEnable_q <= wbEnable_q;
                  if (wbEnable_q) begin
                     rfWbAddr_q <= wbAddr_q;
                     rfWbData_q <= loadWbData_d;
                  end
               end
            end
            WB: begin
               rfWbEnable_q <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// tb_memory_writeback_cycle: directed scenarios plus randomized ops checked
// against an arithmetic reference model of the memory/writeback stage.
module tb_memory_writeback_cycle;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [31:0] alu_result = '0;
   logic [31:0] pc_plus4 = '0;
   logic        rf_write_enable = 1'b0;
   logic [4:0]  rf_write_addr = '0;
   logic [1:0]  rf_write_data_sel = '0;
   logic        dm_read_enable = 1'b0;
   logic        dm_write_enable = 1'b0;
   logic [31:0] dm_write_data = '0;
   logic [2:0]  dm_load_type = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rf_writeback_enable;
   logic [4:0]  rf_writeback_addr;
   logic [31:0] rf_writeback_data;
   logic        misalign_error;

   int          nCompared = 0;
   int          nMismatched = 0;
   logic [4:0]  lastWbAddr = '0;
   logic [31:0] lastWbData = '0;

   typedef struct {
      logic [31:0] alu, pc, wdata;
      logic        rfwe;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic        rden, wren;
      logic [2:0]  lt;
   } op_t;

   typedef struct {
      bit          timeout;
      int          misCount, reqCycles, wbCount, wbCycle, readyCycle;
      bit          reqUnstable;
      logic [31:0] reqAddr, reqWdata, wbData;
      logic [3:0]  reqBe;
      logic        reqWe;
      logic [4:0]  wbAddr;
   } obs_t;

   typedef struct {
      bit          mis, isMem, isStore, wb;
      logic [31:0] addr, wdata, wbData;
      logic [3:0]  be;
   } exp_t;

   memory_writeback_cycle #(.XLEN(32), .REGISTER_SIZE(5)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_result(alu_result), .pc_plus4(pc_plus4),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
      .rf_write_data_sel(rf_write_data_sel),
      .dm_read_enable(dm_read_enable), .dm_write_enable(dm_write_enable),
      .dm_write_data(dm_write_data), .dm_load_type(dm_load_type),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_writeback_enable(rf_writeback_enable),
      .rf_writeback_addr(rf_writeback_addr),
      .rf_writeback_data(rf_writeback_data),
      .misalign_error(misalign_error)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: what the stage should do with one op, from plain arithmetic
   function automatic exp_t model(input op_t op, input logic [31:0] rdata);
      exp_t        e;
      int          size, off;
      logic [31:0] mask, lane;
      e.isMem   = op.rden || op.wren;
      e.isStore = op.wren && !op.rden;
      case (op.lt)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         default:        size = 4;
      endcase
      off      = int'(op.alu[1:0]);
      e.mis    = e.isMem && ((off % size) != 0);
      e.addr   = op.alu - 32'(off);
      e.be     = 4'(((1 << size) - 1) << off);
      e.wdata  = (size == 1) ? op.wdata[7:0] * 32'h01010101 :
                 (size == 2) ? op.wdata[15:0] * 32'h00010001 : op.wdata;
      mask     = (size == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 32'd1;
      lane     = (rdata >> (8 * off)) & mask;
      if ((op.lt == 3'b000 || op.lt == 3'b001) && lane[8*size-1]) lane = lane | ~mask;
      e.wb     = !e.mis && !e.isStore && op.rfwe && (op.rd != 5'd0);
      e.wbData = (op.sel == 2'd2) ? op.pc : (op.sel == 2'd1 && op.rden) ? lane : op.alu;
      return e;
   endfunction

   // Issue one op, play the memory side, and record what the DUT did
   task automatic runOp(input op_t op, input int gntDelay, input int rvDelay,
                        input logic [31:0] rdata, output obs_t o);
      int k;
      bit granted;
      o = '{default: 0};
      k = 0;
      granted = 0;
      alu_result = op.alu; pc_plus4 = op.pc; dm_write_data = op.wdata;
      rf_write_enable = op.rfwe; rf_write_addr = op.rd; rf_write_data_sel = op.sel;
      dm_read_enable = op.rden; dm_write_enable = op.wren; dm_load_type = op.lt;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (misalign_error) o.misCount++;
         if (rf_writeback_enable) begin
            o.wbCount++; o.wbAddr = rf_writeback_addr; o.wbData = rf_writeback_data; o.wbCycle = cyc;
         end
         if (ex_ready) begin
            o.readyCycle = cyc;
            return;
         end
         if (mem_req) begin
            o.reqCycles++;
            if (o.reqCycles == 1) begin
               o.reqAddr = mem_addr; o.reqBe = mem_be; o.reqWe = mem_we; o.reqWdata = mem_wdata;
            end else if (mem_addr !== o.reqAddr || mem_be !== o.reqBe ||
                         mem_we !== o.reqWe || mem_wdata !== o.reqWdata) begin
               o.reqUnstable = 1;
            end
            if (o.reqCycles > gntDelay) begin
               mem_gnt = 1'b1; granted = 1;
               if (rvDelay == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
            end
         end else if (granted) begin
            k++;
            mem_gnt = 1'($urandom);
            if (k == rvDelay) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
         end
         @(posedge clk); #1;
      end
      o.timeout = 1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      nCompared++;
      if ({mem_req, mem_we, mem_be, rf_writeback_enable, misalign_error} !== 8'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                  {mem_req, mem_we, mem_be, rf_writeback_enable, misalign_error});
      end
      nCompared++;
      if ({mem_addr, mem_wdata, rf_writeback_addr, rf_writeback_data} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL reset_data: got %h %h %h %h expected all zero",
                  mem_addr, mem_wdata, rf_writeback_addr, rf_writeback_data);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      nCompared++;
      if (ex_ready !== 1'b1) begin
         nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", ex_ready);
      end
   endtask

   task automatic test_alu();
      op_t  op;
      obs_t o;
      op = '{alu: 32'h1234, pc: 32'h8, wdata: 32'h0, rfwe: 1'b1, rd: 5'd5, sel: 2'b00,
             rden: 1'b0, wren: 1'b0, lt: 3'b010};
      runOp(op, 0, 0, 32'h0, o);
      nCompared++;
      if (o.wbCount !== 1 || o.wbCycle !== 1) begin
         nMismatched++; $display("[TB] FAIL alu_latency: got count %0d cycle %0d expected 1 1", o.wbCount, o.wbCycle);
      end
      nCompared++;
      if (o.wbAddr !== 5'd5 || o.wbData !== 32'h1234) begin
         nMismatched++; $display("[TB] FAIL alu_wb: got %0d/%h expected 5/00001234", o.wbAddr, o.wbData);
      end
      nCompared++;
      if (o.reqCycles !== 0) begin
         nMismatched++; $display("[TB] FAIL alu_no_req: got %0d request cycles expected 0", o.reqCycles);
      end
      lastWbAddr = 5'd5; lastWbData = 32'h1234;
   endtask

   task automatic test_lb();
      op_t  op;
      obs_t o;
      op = '{alu: 32'h103, pc: 32'h0, wdata: 32'h0, rfwe: 1'b1, rd: 5'd7, sel: 2'b01,
             rden: 1'b1, wren: 1'b0, lt: 3'b000};
      runOp(op, 2, 1, 32'h80FFFFFF, o);
      nCompared++;
      if (o.reqAddr !== 32'h100 || o.reqBe !== 4'b1000 || o.reqWe !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL lb_request: got addr %h be %b we %b expected 00000100 1000 0", o.reqAddr, o.reqBe, o.reqWe);
      end
      nCompared++;
      if (o.reqCycles !== 3 || o.reqUnstable) begin
         nMismatched++; $display("[TB] FAIL lb_req_hold: got %0d cycles unstable %0d expected 3 0", o.reqCycles, o.reqUnstable);
      end
      nCompared++;
      if (o.wbCount !== 1 || o.wbAddr !== 5'd7 || o.wbData !== 32'hFFFFFF80 || o.wbCycle !== 5) begin
         nMismatched++;
         $display("[TB] FAIL lb_wb: got count %0d rd %0d data %h cycle %0d expected 1 7 ffffff80 5",
                  o.wbCount, o.wbAddr, o.wbData, o.wbCycle);
      end
      lastWbAddr = 5'd7; lastWbData = 32'hFFFFFF80;
   endtask

   task automatic test_sh();
      op_t  op;
      obs_t o;
      op = '{alu: 32'h202, pc: 32'h0, wdata: 32'h5555ABCD, rfwe: 1'b1, rd: 5'd3, sel: 2'b00,
             rden: 1'b0, wren: 1'b1, lt: 3'b001};
      runOp(op, 1, 0, 32'h0, o);
      nCompared++;
      if (o.reqWe !== 1'b1 || o.reqBe !== 4'b1100 || o.reqWdata !== 32'hABCDABCD || o.reqAddr !== 32'h200) begin
         nMismatched++;
         $display("[TB] FAIL sh_request: got we %b be %b wdata %h addr %h expected 1 1100 abcdabcd 00000200",
                  o.reqWe, o.reqBe, o.reqWdata, o.reqAddr);
      end
      nCompared++;
      if (o.wbCount !== 0 || o.readyCycle !== 3) begin
         nMismatched++; $display("[TB] FAIL sh_no_wb: got wb %0d ready %0d expected 0 3", o.wbCount, o.readyCycle);
      end
      nCompared++;
      if (rf_writeback_addr !== lastWbAddr || rf_writeback_data !== lastWbData) begin
         nMismatched++;
         $display("[TB] FAIL sh_hold: got %0d/%h expected %0d/%h", rf_writeback_addr, rf_writeback_data, lastWbAddr, lastWbData);
      end
   endtask

   task automatic test_misalign();
      op_t  op;
      obs_t o;
      op = '{alu: 32'h101, pc: 32'h0, wdata: 32'h0, rfwe: 1'b1, rd: 5'd9, sel: 2'b01,
             rden: 1'b1, wren: 1'b0, lt: 3'b010};
      runOp(op, 0, 0, 32'h12345678, o);
      nCompared++;
      if (o.misCount !== 1 || o.reqCycles !== 0 || o.wbCount !== 0 || o.readyCycle !== 1) begin
         nMismatched++;
         $display("[TB] FAIL misalign_lw: got pulse %0d req %0d wb %0d ready %0d expected 1 0 0 1",
                  o.misCount, o.reqCycles, o.wbCount, o.readyCycle);
      end
      @(posedge clk); #1;
      nCompared++;
      if (misalign_error !== 1'b0) begin
         nMismatched++; $display("[TB] FAIL misalign_pulse_width: got %b expected 0", misalign_error);
      end
   endtask

   task automatic test_x0_and_link();
      op_t  op;
      obs_t o;
      op = '{alu: 32'h40, pc: 32'h0, wdata: 32'h0, rfwe: 1'b1, rd: 5'd0, sel: 2'b01,
             rden: 1'b1, wren: 1'b0, lt: 3'b010};
      runOp(op, 0, 2, 32'hCAFEF00D, o);
      nCompared++;
      if (o.reqCycles !== 1 || o.wbCount !== 0 || o.readyCycle !== 5) begin
         nMismatched++;
         $display("[TB] FAIL x0_load: got req %0d wb %0d ready %0d expected 1 0 5", o.reqCycles, o.wbCount, o.readyCycle);
      end
      op = '{alu: 32'h999, pc: 32'h44, wdata: 32'h0, rfwe: 1'b1, rd: 5'd1, sel: 2'b10,
             rden: 1'b0, wren: 1'b0, lt: 3'b010};
      runOp(op, 0, 0, 32'h0, o);
      nCompared++;
      if (o.wbCount !== 1 || o.wbAddr !== 5'd1 || o.wbData !== 32'h44) begin
         nMismatched++;
         $display("[TB] FAIL link_wb: got count %0d rd %0d data %h expected 1 1 00000044", o.wbCount, o.wbAddr, o.wbData);
      end
      lastWbAddr = 5'd1; lastWbData = 32'h44;
   endtask

   task automatic test_reset_midop();
      int wbSeen;
      for (int pass = 0; pass < 2; pass++) begin
         alu_result = 32'h80; dm_read_enable = 1'b1; dm_write_enable = 1'b0; dm_load_type = 3'b010;
         rf_write_enable = 1'b1; rf_write_addr = 5'd4; rf_write_data_sel = 2'b01;
         ex_valid = 1'b1;
         @(posedge clk); #1;
         ex_valid = 1'b0;
         if (pass == 0) begin
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
         end
         #2 rst = 1'b0;
         #1;
         nCompared++;
         if (mem_req !== 1'b0 || ex_ready !== 1'b1 || rf_writeback_data !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_midop%0d: got req %b ready %b wbdata %h expected 0 1 00000000",
                     pass, mem_req, ex_ready, rf_writeback_data);
         end
         @(posedge clk); #1;
         rst = 1'b1;
         lastWbAddr = '0; lastWbData = '0;
         wbSeen = 0;
         mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (rf_writeback_enable) wbSeen++;
         end
         nCompared++;
         if (wbSeen !== 0 || ex_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_late_rvalid%0d: got wb %0d ready %b expected 0 1", pass, wbSeen, ex_ready);
         end
      end
   endtask

   task automatic test_random();
      op_t         op;
      obs_t        o;
      exp_t        e;
      int          gd, rv, expReq, expReady;
      logic [31:0] rdata;
      for (int n = 0; n < 60; n++) begin
         op.rden = ($urandom_range(0, 2) == 0);
         op.wren = ($urandom_range(0, 2) == 0);
         op.lt = 3'($urandom); op.alu = $urandom; op.pc = $urandom; op.wdata = $urandom;
         if ($urandom_range(0, 1) == 1) op.alu[1:0] = 2'b00;
         op.rfwe = ($urandom_range(0, 3) != 0);
         op.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         op.sel = 2'($urandom);
         if (!op.rden && op.sel == 2'b01) op.sel = 2'b00;
         gd = $urandom_range(0, 3); rv = $urandom_range(0, 3); rdata = $urandom;
         e = model(op, rdata);
         expReq   = (e.isMem && !e.mis) ? gd + 1 : 0;
         expReady = e.mis ? 1 : !e.isMem ? 2 : e.isStore ? gd + 2 : gd + rv + 3;
         runOp(op, gd, rv, rdata, o);
         nCompared++;
         if (o.timeout || o.readyCycle !== expReady) begin
            nMismatched++;
            $display("[TB] FAIL rnd%0d_ready: got cycle %0d timeout %0d expected %0d", n, o.readyCycle, o.timeout, expReady);
         end
         nCompared++;
         if (o.misCount !== int'(e.mis) || o.reqCycles !== expReq) begin
            nMismatched++;
            $display("[TB] FAIL rnd%0d_req: got misalign %0d req %0d expected %0d %0d", n, o.misCount, o.reqCycles, e.mis, expReq);
         end
         if (expReq > 0) begin
            nCompared++;
            if (o.reqAddr !== e.addr || o.reqBe !== e.be || o.reqWe !== e.isStore ||
                (e.isStore && o.reqWdata !== e.wdata) || o.reqUnstable) begin
               nMismatched++;
               $display("[TB] FAIL rnd%0d_memif: got %h %b %b %h unstable %0d expected %h %b %b %h",
                        n, o.reqAddr, o.reqBe, o.reqWe, o.reqWdata, o.reqUnstable, e.addr, e.be, e.isStore, e.wdata);
            end
         end
         nCompared++;
         if (o.wbCount !== int'(e.wb)) begin
            nMismatched++; $display("[TB] FAIL rnd%0d_wb_count: got %0d expected %0d", n, o.wbCount, e.wb);
         end
         if (e.wb) begin
            nCompared++;
            if (o.wbAddr !== op.rd || o.wbData !== e.wbData ||
                o.wbCycle !== (e.isMem ? gd + rv + 2 : 1)) begin
               nMismatched++;
               $display("[TB] FAIL rnd%0d_wb: got %0d/%h cycle %0d expected %0d/%h cycle %0d",
                        n, o.wbAddr, o.wbData, o.wbCycle, op.rd, e.wbData, e.isMem ? gd + rv + 2 : 1);
            end
            lastWbAddr = op.rd; lastWbData = e.wbData;
         end
         nCompared++;
         if (rf_writeback_addr !== lastWbAddr || rf_writeback_data !== lastWbData) begin
            nMismatched++;
            $display("[TB] FAIL rnd%0d_hold: got %0d/%h expected %0d/%h", n, rf_writeback_addr, rf_writeback_data, lastWbAddr, lastWbData);
         end
         if ($urandom_range(0, 2) == 0) begin
            mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb();
      test_sh();
      test_misalign();
      test_x0_and_link();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
